// File: rtl/hsv_core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hsv_core_pkg
// Description : Shared types and constants for the hsv core commit stage.
//               - commit_data_t  : result payload delivered by each execution unit
//               - commit_state_t : commit FSM encoding (RUN / FLUSH)
//               - NUM_PU         : number of result channels
//                                  (0=ALU, 1=branch, 2=ctrl_status, 3=mem)
// Revision    : 1.0 - initial release
// ============================================================================
package hsv_core_pkg;

    localparam int NUM_PU = 4;
    localparam int PTR_W  = $clog2(NUM_PU);

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] word_t;

    typedef struct packed {
        reg_addr_t rd_addr;
        word_t     rd_value;
        logic      writeback;
        logic      jump;
        word_t     next_pc;
    } commit_data_t;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } commit_state_t;

endpackage : hsv_core_pkg
`default_nettype wire

// File: rtl/hsv_core_commit_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : hsv_core_commit_arbiter
// Description : Round-robin arbiter over the commit result channels.
//               The search starts at the pointer rr; after a grant the
//               pointer moves to the slot after the winner, otherwise it holds.
// Ports       : clk_core, rst_core_n - clock, synchronous active-low reset
//               req    - per-channel request
//               enable - allow a grant this cycle
//               clear  - return the pointer to channel 0
//               gnt    - one-hot grant (combinational)
//               rr     - current round-robin pointer
// Revision    : 1.0 - initial release
// ============================================================================
module hsv_core_commit_arbiter
    import hsv_core_pkg::*;
(
    input  logic              clk_core,
    input  logic              rst_core_n,
    input  logic [NUM_PU-1:0] req,
    input  logic              enable,
    input  logic              clear,
    output logic [NUM_PU-1:0] gnt,
    output logic [PTR_W-1:0]  rr
);

    logic [PTR_W-1:0]  rr_q;
    logic [PTR_W-1:0]  rr_d;
    logic [NUM_PU-1:0] gnt_w;
    logic [PTR_W-1:0]  idx_w;
    logic              found_w;

    // NUM_PU is a power of two, so the PTR_W-bit additions wrap modulo NUM_PU.
    always_comb begin
        gnt_w   = '0;
        rr_d    = rr_q;
        idx_w   = rr_q;
        found_w = 1'b0;
        if (enable) begin
            for (int i = 0; i < NUM_PU; i++) begin
                idx_w = rr_q + PTR_W'(i);
                if (!found_w && req[idx_w]) begin
                    found_w      = 1'b1;
                    gnt_w[idx_w] = 1'b1;
                    rr_d         = idx_w + PTR_W'(1);
                end
            end
        end
        if (clear) begin
            rr_d = '0;
        end
    end

    always_ff @(posedge clk_core) begin
        if (!rst_core_n) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

    assign gnt = gnt_w;
    assign rr  = rr_q;

endmodule : hsv_core_commit_arbiter
`default_nettype wire

// File: rtl/hsv_core_commit.sv
`default_nettype none
// ============================================================================
// Module      : hsv_core_commit
// Description : Commit/writeback stage. Accepts at most one completed result
//               per cycle from the ALU, branch, ctrl_status and mem units via
//               round-robin arbitration, drives the register-file write port,
//               and on a control-flow change publishes the redirect PC and
//               holds a flush request until every stage acknowledges.
// Ports       : clk_core, rst_core_n       - clock, synchronous active-low reset
//               *_commit / *_valid_i       - per-unit result payload and valid
//               *_ready_o                  - per-unit payload consumed
//               wr_addr / wr_data / wr_en  - register-file write port
//               redirect_pc / redirect_valid - fetch redirect (1-cycle pulse)
//               flush_req / flush_ack      - pipeline flush handshake
//               retired                    - one pulse per committed instruction
// Revision    : 1.0 - initial release
// ============================================================================
module hsv_core_commit
    import hsv_core_pkg::*;
(
    input  logic         clk_core,
    input  logic         rst_core_n,

    input  commit_data_t alu_commit,
    input  commit_data_t branch_commit,
    input  commit_data_t ctrl_status_commit,
    input  commit_data_t mem_commit,

    input  logic         alu_valid_i,
    input  logic         branch_valid_i,
    input  logic         ctrl_status_valid_i,
    input  logic         mem_valid_i,

    output logic         alu_ready_o,
    output logic         branch_ready_o,
    output logic         ctrl_status_ready_o,
    output logic         mem_ready_o,

    output logic [4:0]   wr_addr,
    output logic [31:0]  wr_data,
    output logic         wr_en,

    output logic [31:0]  redirect_pc,
    output logic         redirect_valid,
    output logic         flush_req,
    input  logic         flush_ack,

    output logic         retired
);

    // ------------------------------------------------------------------
    // Channel gathering
    // ------------------------------------------------------------------
    logic [NUM_PU-1:0] valid_w;
    logic [NUM_PU-1:0] gnt_w;
    logic [NUM_PU-1:0] ready_w;
    logic [PTR_W-1:0]  rr_w;
    commit_data_t      payload_w [NUM_PU];
    commit_data_t      sel_w;
    logic              grant_w;

    assign valid_w      = {mem_valid_i, ctrl_status_valid_i, branch_valid_i, alu_valid_i};
    assign payload_w[0] = alu_commit;
    assign payload_w[1] = branch_commit;
    assign payload_w[2] = ctrl_status_commit;
    assign payload_w[3] = mem_commit;

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    commit_state_t state_q, state_d;
    logic          wr_en_q, wr_en_d;
    reg_addr_t     wr_addr_q, wr_addr_d;
    word_t         wr_data_q, wr_data_d;
    logic          retired_q, retired_d;
    logic          redirect_valid_q, redirect_valid_d;
    word_t         redirect_pc_q, redirect_pc_d;
    logic          flush_req_q, flush_req_d;

    logic          arb_enable_w;
    logic          arb_clear_w;

    // Grants only happen in RUN and never while reset is held, which keeps
    // every ready output low during reset.
    assign arb_enable_w = rst_core_n && (state_q == RUN);
    // Leaving FLUSH restarts arbitration from the ALU channel.
    assign arb_clear_w  = (state_q == FLUSH) && flush_ack;

    hsv_core_commit_arbiter u_arbiter (
        .clk_core   (clk_core),
        .rst_core_n (rst_core_n),
        .req        (valid_w),
        .enable     (arb_enable_w),
        .clear      (arb_clear_w),
        .gnt        (gnt_w),
        .rr         (rr_w)
    );

    // One-hot grant selects the payload to commit.
    always_comb begin
        sel_w = '0;
        for (int i = 0; i < NUM_PU; i++) begin
            if (gnt_w[i]) begin
                sel_w = payload_w[i];
            end
        end
    end

    assign grant_w = |gnt_w;

    // In FLUSH every channel is drained so younger results are discarded.
    always_comb begin
        ready_w = '0;
        if (rst_core_n) begin
            if (state_q == FLUSH) begin
                ready_w = '1;
            end else begin
                ready_w = gnt_w;
            end
        end
    end

    assign alu_ready_o         = ready_w[0];
    assign branch_ready_o      = ready_w[1];
    assign ctrl_status_ready_o = ready_w[2];
    assign mem_ready_o         = ready_w[3];

    // ------------------------------------------------------------------
    // FSM next-state and registered-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d          = state_q;
        wr_en_d          = 1'b0;
        wr_addr_d        = wr_addr_q;
        wr_data_d        = wr_data_q;
        retired_d        = 1'b0;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        flush_req_d      = flush_req_q;

        case (state_q)
            RUN: begin
                if (grant_w) begin
                    // x0 is hardwired zero, so it is never written.
                    wr_en_d   = sel_w.writeback && (sel_w.rd_addr != '0);
                    wr_addr_d = sel_w.rd_addr;
                    wr_data_d = sel_w.rd_value;
                    retired_d = 1'b1;
                    if (sel_w.jump) begin
                        redirect_valid_d = 1'b1;
                        redirect_pc_d    = sel_w.next_pc;
                        flush_req_d      = 1'b1;
                        state_d          = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (flush_ack) begin
                    flush_req_d = 1'b0;
                    state_d     = RUN;
                end
            end
            default: begin
                state_d     = RUN;
                flush_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_core) begin
        if (!rst_core_n) begin
            state_q          <= RUN;
            wr_en_q          <= 1'b0;
            wr_addr_q        <= '0;
            wr_data_q        <= '0;
            retired_q        <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_req_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            wr_en_q          <= wr_en_d;
            wr_addr_q        <= wr_addr_d;
            wr_data_q        <= wr_data_d;
            retired_q        <= retired_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_req_q      <= flush_req_d;
        end
    end

    assign wr_en          = wr_en_q;
    assign wr_addr        = wr_addr_q;
    assign wr_data        = wr_data_q;
    assign retired        = retired_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush_req      = flush_req_q;

endmodule : hsv_core_commit
`default_nettype wire
